onchip_mem_arbiter: RTL and testbench

ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

---
 rtl/onchip_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port on-chip RAM.
// Out-of-range accesses are completed locally and the first one is logged in sticky error status.
module onchip_mem_arbiter #(
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned DEPTH     = 100240,
  parameter logic [31:0] FILL_WORD = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] s0_address,
  input  logic [3:0]        s0_byteenable,
  input  logic              s0_read,
  input  logic              s0_write,
  input  logic [31:0]       s0_writedata,
  output logic              s0_waitrequest,
  output logic [31:0]       s0_readdata,
  output logic              s0_readdatavalid,
  input  logic [ADDR_W-1:0] s1_address,
  input  logic [3:0]        s1_byteenable,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [31:0]       s1_writedata,
  output logic              s1_waitrequest,
  output logic [31:0]       s1_readdata,
  output logic              s1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  input  logic              freeze,
  input  logic              err_clear,
  output logic              err_flag,
  output logic              err_port,
  output logic [ADDR_W-1:0] err_addr
);

  logic              req0, req1;
  logic              grant0, grant1, grant_valid;
  logic              sel_write, in_range, accept_read, oor_access;
  logic [ADDR_W-1:0] sel_addr;
  logic              last_grant;
  logic              rd_valid0, rd_valid1, rd_oor;

  assign req0 = s0_read | s0_write;
  assign req1 = s1_read | s1_write;

  // Round-robin: under contention the port that did not win last time is granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!freeze) begin
      if (req0 && req1) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  assign grant_valid    = grant0 | grant1;
  assign s0_waitrequest = req0 & ~grant0;
  assign s1_waitrequest = req1 & ~grant1;

  assign sel_addr  = grant1 ? s1_address : s0_address;
  assign sel_write = grant1 ? s1_write   : s0_write;
  assign in_range  = (64'(sel_addr) < 64'(DEPTH));

  assign mem_address    = sel_addr;
  assign mem_byteenable = grant1 ? s1_byteenable : s0_byteenable;
  assign mem_writedata  = grant1 ? s1_writedata  : s0_writedata;
  assign mem_chipselect = grant_valid & in_range;
  assign mem_write      = mem_chipselect & sel_write;
  assign mem_clken      = 1'b1;

  assign accept_read = grant_valid & ~sel_write;
  assign oor_access  = grant_valid & ~in_range;

  // Read return pipeline: one cycle, tagged with owner and range status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid0  <= 1'b0;
      rd_valid1  <= 1'b0;
      rd_oor     <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      rd_valid0 <= accept_read & grant0;
      rd_valid1 <= accept_read & grant1;
      rd_oor    <= ~in_range;
      if (grant_valid) begin
        last_grant <= grant1;
      end
    end
  end

  assign s0_readdatavalid = rd_valid0;
  assign s1_readdatavalid = rd_valid1;
  assign s0_readdata      = rd_oor ? FILL_WORD : mem_readdata;
  assign s1_readdata      = rd_oor ? FILL_WORD : mem_readdata;

  // Sticky error capture; a new error beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_flag <= 1'b0;
      err_port <= 1'b0;
      err_addr <= '0;
    end else if (oor_access && (!err_flag || err_clear)) begin
      err_flag <= 1'b1;
      err_port <= grant1;
      err_addr <= sel_addr;
    end else if (err_clear) begin
      err_flag <= 1'b0;
      err_port <= 1'b0;
      err_addr <= '0;
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grants, RAM traffic, read returns and error status.
module tb_onchip_mem_arbiter;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DEPTH  = 100240;
  localparam logic [31:0] FILL   = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] s0_address, s1_address;
  logic [3:0]        s0_byteenable, s1_byteenable;
  logic              s0_read, s0_write, s1_read, s1_write;
  logic [31:0]       s0_writedata, s1_writedata;
  logic              s0_waitrequest, s1_waitrequest;
  logic [31:0]       s0_readdata, s1_readdata;
  logic              s0_readdatavalid, s1_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_writedata;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [31:0]       mem_readdata = 32'h0;
  logic              freeze, err_clear;
  logic              err_flag, err_port;
  logic [ADDR_W-1:0] err_addr;

  onchip_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .s0_address(s0_address), .s0_byteenable(s0_byteenable), .s0_read(s0_read),
    .s0_write(s0_write), .s0_writedata(s0_writedata), .s0_waitrequest(s0_waitrequest),
    .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_read(s1_read),
    .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_waitrequest(s1_waitrequest),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .freeze(freeze), .err_clear(err_clear),
    .err_flag(err_flag), .err_port(err_port), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM with one-cycle read latency.
  logic [31:0] ram [int];
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        logic [31:0] w;
        w = ram.exists(int'(mem_address)) ? ram[int'(mem_address)] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) w[8*b +: 8] = mem_writedata[8*b +: 8];
        ram[int'(mem_address)] = w;
      end else begin
        mem_readdata <= ram.exists(int'(mem_address)) ? ram[int'(mem_address)] : 32'h0;
      end
    end
  end

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [int];
  int          m_last;
  logic        m_err_flag;
  int          m_err_port;
  logic [31:0] m_err_addr;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_last     = 1;
    m_err_flag = 1'b0;
    m_err_port = 0;
    m_err_addr = 32'h0;
  endtask

  task automatic idle_inputs();
    s0_read = 0; s0_write = 0; s1_read = 0; s1_write = 0;
    freeze = 0; err_clear = 0;
  endtask

  task automatic set_port(input int p, input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                          input logic [3:0] be, input logic [31:0] d);
    if (p == 0) begin
      s0_read = rd; s0_write = wr; s0_address = a; s0_byteenable = be; s0_writedata = d;
    end else begin
      s1_read = rd; s1_write = wr; s1_address = a; s1_byteenable = be; s1_writedata = d;
    end
  endtask

  // One cycle: check combinational outputs and error status at negedge, update the model.
  task automatic step();
    bit          rq0, rq1, wr, inr;
    int          win, a;
    logic [31:0] w;
    exp_t        e;
    @(negedge clk);
    chk("err_flag", 32'(err_flag), 32'(m_err_flag));
    chk("err_port", 32'(err_port), 32'(m_err_port));
    chk("err_addr", 32'(err_addr), m_err_addr);
    chk("mem_clken", 32'(mem_clken), 32'd1);
    rq0 = s0_read | s0_write;
    rq1 = s1_read | s1_write;
    if (freeze)           win = -1;
    else if (rq0 && rq1)  win = (m_last == 0) ? 1 : 0;
    else if (rq0)         win = 0;
    else if (rq1)         win = 1;
    else                  win = -1;
    chk("s0_waitrequest", 32'(s0_waitrequest), 32'(rq0 && win != 0));
    chk("s1_waitrequest", 32'(s1_waitrequest), 32'(rq1 && win != 1));
    if (win >= 0) begin
      a   = (win == 1) ? int'(s1_address) : int'(s0_address);
      wr  = (win == 1) ? s1_write : s0_write;
      inr = (a < int'(DEPTH));
      chk("mem_chipselect", 32'(mem_chipselect), 32'(inr));
      chk("mem_write", 32'(mem_write), 32'(inr && wr));
      if (inr) chk("mem_address", 32'(mem_address), 32'(a));
      if (wr && inr) begin
        w = ref_rd(a);
        for (int b = 0; b < 4; b++)
          if (((win == 1) ? s1_byteenable[b] : s0_byteenable[b]))
            w[8*b +: 8] = (win == 1) ? s1_writedata[8*b +: 8] : s0_writedata[8*b +: 8];
        ref_mem[a] = w;
      end
      if (!wr) begin
        e.port = win;
        e.data = inr ? ref_rd(a) : FILL;
        e.due  = cyc + 1;
        q.push_back(e);
      end
      if (!inr && (!m_err_flag || err_clear)) begin
        m_err_flag = 1'b1;
        m_err_port = win;
        m_err_addr = 32'(a);
      end else if (err_clear) begin
        m_err_flag = 1'b0; m_err_port = 0; m_err_addr = 32'h0;
      end
      m_last = win;
    end else begin
      chk("mem_chipselect_idle", 32'(mem_chipselect), 32'd0);
      chk("mem_write_idle", 32'(mem_write), 32'd0);
      if (err_clear) begin
        m_err_flag = 1'b0; m_err_port = 0; m_err_addr = 32'h0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Pops an expected read whenever a readdatavalid appears, or when one is overdue.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (s0_readdatavalid || s1_readdatavalid) begin
        chk("rdv_both", 32'(s0_readdatavalid & s1_readdatavalid), 32'd0);
        if (q.size() == 0) begin
          chk("rdv_unexpected", 32'(s0_readdatavalid | s1_readdatavalid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("rdv_port", s1_readdatavalid ? 32'd1 : 32'd0, 32'(e.port));
          chk("rdv_cycle", 32'(cyc), 32'(e.due));
          chk("readdata", (e.port == 1) ? s1_readdata : s0_readdata, e.data);
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk("rdv_missing", 32'((e.port == 1) ? s1_readdatavalid : s0_readdatavalid), 32'd1);
      end
    end
  endtask

  initial begin
    reset_n = 0;
    idle_inputs();
    set_port(0, 0, 0, '0, 4'h0, 32'h0);
    set_port(1, 0, 0, '0, 4'h0, 32'h0);
    model_reset();
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s0_rdv", 32'(s0_readdatavalid), 32'd0);
    chk("rst_s1_rdv", 32'(s1_readdatavalid), 32'd0);
    chk("rst_err_flag", 32'(err_flag), 32'd0);
    chk("rst_err_addr", 32'(err_addr), 32'd0);
    @(posedge clk); #1;
    reset_n = 1;

    // Both ports reading from reset alternate 0,1,0,1,...
    set_port(0, 1, 0, 17'h00003, 4'hF, 32'h0);
    set_port(1, 1, 0, 17'h00004, 4'hF, 32'h0);
    repeat (6) step();
    idle_inputs();
    step();

    // Write from s0, read back through s1.
    set_port(0, 0, 1, 17'h00010, 4'hF, 32'h12345678);
    step();
    idle_inputs();
    set_port(1, 1, 0, 17'h00010, 4'hF, 32'h0);
    step();
    idle_inputs();
    step();

    // Out-of-range read on s1, then out-of-range write on s0 leaves captures alone.
    set_port(1, 1, 0, 17'(DEPTH), 4'hF, 32'h0);
    step();
    idle_inputs();
    set_port(0, 0, 1, 17'(DEPTH + 60), 4'hF, 32'hCAFEF00D);
    step();
    idle_inputs();
    step();

    // Error coinciding with err_clear wins.
    err_clear = 1;
    set_port(0, 1, 0, 17'h1FFFF, 4'hF, 32'h0);
    step();
    idle_inputs();
    step();
    err_clear = 1;
    step();
    idle_inputs();
    step();

    // Freeze with both requesting; the read accepted just before still returns.
    set_port(0, 1, 0, 17'h00010, 4'hF, 32'h0);
    set_port(1, 1, 0, 17'h00003, 4'hF, 32'h0);
    step();
    freeze = 1;
    repeat (3) step();
    freeze = 0;
    repeat (2) step();
    idle_inputs();
    step();

    // Reset right after an accepted read drops the return; port 0 wins afterwards.
    set_port(1, 1, 0, 17'h00010, 4'hF, 32'h0);
    step();
    reset_n = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    set_port(0, 1, 0, 17'h00010, 4'hF, 32'h0);
    set_port(1, 1, 0, 17'h00003, 4'hF, 32'h0);
    repeat (2) step();
    idle_inputs();
    step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        int unsigned kind;
        logic [ADDR_W-1:0] a;
        kind = $urandom_range(0, 9);
        a = ($urandom_range(0, 19) == 0) ? 17'(DEPTH + $urandom_range(0, 131071 - DEPTH))
                                         : 17'($urandom_range(0, 15));
        set_port(p, kind inside {[0:3], 8}, kind inside {[4:6], 8}, a,
                 4'($urandom_range(0, 15)), $urandom);
      end
      freeze    = ($urandom_range(0, 9) == 0);
      err_clear = ($urandom_range(0, 19) == 0);
      step();
    end
    idle_inputs();
    repeat (3) step();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
